muldiv_unit_ctrl: RTL and testbench
===================================

Name: muldiv_unit_ctrl

Overview:
Sequencing controller and iterative engine for the RV32M multiply/divide resource in the EX stage. It accepts one operation from EX and runs a radix-2 shift-add multiply or restoring divide over XLEN cycles. It drives the busy/ready handshake that the pipeline hazard logic uses to stall ID and EX. It handles divide-by-zero, signed overflow and pipeline kill.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  EX holds a valid M-extension op; sampled only in IDLE
kill  in  1  pipeline flush (branch/exception); aborts any in-flight op
op  in  3  funct3: MUL=000 MULH=001 MULHSU=010 MULHU=011 DIV=100 DIVU=101 REM=110 REMU=111
rs1_data  in  XLEN  operand A
rs2_data  in  XLEN  operand B
busy  out  1  op in progress (CALC or FIX)
ready  out  1  result valid; one-cycle pulse
result  out  XLEN  final value; held stable until the next completion

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, ready=0, result=0; counter and operand registers cleared. Reset mid-operation discards the op with no ready pulse.
- States: IDLE, CALC, FIX, DONE. busy = (CALC|FIX). ready = (state==DONE). Both outputs are registered state decodes.
- IDLE with start=1 and kill=0: latch op, sign flags and operand magnitudes, then branch on op:
  - Divide op with rs2_data==0: go to DONE. result = all-ones for DIV/DIVU; result = rs1_data for REM/REMU.
  - DIV/REM with rs1_data=0x8000_0000 (MSB only) and rs2_data=all-ones: go to DONE. DIV result = rs1_data; REM result = 0.
  - Otherwise: counter=0, go to CALC.
- Signedness:
  - rs1 is signed for MULH, MULHSU, DIV, REM.
  - rs2 is signed for MULH, DIV, REM.
  - MUL uses the low half, so signedness is irrelevant; treat it as unsigned.
- CALC runs exactly XLEN cycles, one bit per cycle.
  - Multiply: 2*XLEN accumulator, shift-add on magnitudes.
  - Divide: restoring step on magnitudes producing quotient and remainder.
  - Leave when counter==XLEN-1, then go to FIX.
- FIX (1 cycle): sign-correct and write result.
  - Multiply: negate the 2*XLEN product if signA^signB. MUL takes the low half; the other multiplies take the high half.
  - Quotient: negate if signA^signB.
  - Remainder: negate if signA.
  - Go to DONE.
- DONE (1 cycle): ready=1, then go to IDLE unconditionally. start is ignored in DONE, so the retiring instruction is never re-issued.
- Latency, with start sampled at the edge ending cycle 0:
  - Normal path: CALC occupies cycles 1..XLEN, FIX is cycle XLEN+1, ready=1 in cycle XLEN+2 (34 for XLEN=32).
  - Special cases: ready=1 in cycle 1.
- Back-to-back: a new start is accepted in the first IDLE cycle after DONE, so the minimum issue interval is XLEN+3 cycles.
- kill (any state, including the IDLE+start cycle): next state IDLE, busy=0, no ready pulse, result unchanged. kill has priority over start. kill during DONE still lets the current ready cycle complete, because ready is registered.
- Operand or op changes after acceptance are ignored.
- result changes only on entry to DONE.
- Arithmetic is unsigned on magnitudes. Negation is two's complement and truncates to the destination width.

Decomposition:
- Package muldiv_pkg holds:
  - the op funct3 localparams (MUL..REMU);
  - the state enum/localparams (IDLE, CALC, FIX, DONE);
  - helper predicates is_div(op), rs1_signed(op), rs2_signed(op).
- No sub-module: FSM and iteration datapath stay in one module (about 200 lines).

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> busy cycles 1..33, ready cycle 34, result=0xFFFFFFEB. Hold start high through DONE -> no re-issue (busy drops for 1 cycle at 35, then re-accepts only if start is still high in IDLE).
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0. Every case has ready in cycle 1 and busy never asserts.
- Start DIV, assert kill in cycle 10 -> busy=0 from cycle 11, no ready, result unchanged. A start in cycle 11 is accepted with normal latency. rst pulsed mid-CALC -> same behaviour and result=0.
- start and kill together in IDLE -> op not accepted, busy stays 0. Random op/operands back-to-back vs reference model -> all results match.

Source files
------------

// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg : shared op encodings, FSM states and op-decode helpers
// Revision   : 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic rs1_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit_ctrl.sv
// ============================================================================
// muldiv_unit_ctrl : RV32M sequencer with radix-2 shift-add multiply and
//                    restoring divide, busy/ready handshake and kill support
// Revision         : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            ready,
  output logic [XLEN-1:0] result
);

  localparam int            CW       = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state, state_n;
  logic [2:0]          op_q;
  logic                sign_a, sign_b;
  logic [XLEN-1:0]     mag_b;
  logic [2*XLEN-1:0]   acc;
  logic [CW-1:0]       cnt;

  logic                rs1_neg, rs2_neg;
  logic [XLEN-1:0]     rs1_mag, rs2_mag;
  logic                div_zero, div_ovf;
  logic [XLEN-1:0]     special_res;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       div_trial;
  logic                div_ge;
  logic [XLEN-1:0]     div_sub;
  logic [2*XLEN-1:0]   div_next;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo, rem;
  logic [XLEN-1:0]     fix_res;

  // Operand decode for the IDLE acceptance cycle
  always_comb begin
    rs1_neg  = rs1_signed(op) & rs1_data[XLEN-1];
    rs2_neg  = rs2_signed(op) & rs2_data[XLEN-1];
    rs1_mag  = rs1_neg ? -rs1_data : rs1_data;
    rs2_mag  = rs2_neg ? -rs2_data : rs2_data;
    div_zero = is_div(op) && (rs2_data == '0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
               (rs1_data == MIN_NEG) && (rs2_data == '1);
    // op[1] separates REM/REMU from DIV/DIVU
    if (div_zero) special_res = op[1] ? rs1_data : '1;
    else          special_res = op[1] ? '0 : rs1_data;
  end

  // One iteration step; acc = {high/remainder, low/multiplier-or-quotient}
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mag_b};
    mul_next  = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
    div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_ge    = (div_trial >= {1'b0, mag_b});
    div_sub   = div_trial[XLEN-1:0] - mag_b;
    div_next  = div_ge ? {div_sub, acc[XLEN-2:0], 1'b1}
                       : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

  // Sign correction applied in FIX
  always_comb begin
    prod = (sign_a ^ sign_b) ? -acc : acc;
    quo  = acc[XLEN-1:0];
    rem  = acc[2*XLEN-1:XLEN];
    if (is_div(op_q)) begin
      if (op_q[1]) fix_res = sign_a ? -rem : rem;
      else         fix_res = (sign_a ^ sign_b) ? -quo : quo;
    end else begin
      fix_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (start) state_n = (div_zero || div_ovf) ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt == LAST_CNT) state_n = ST_FIX;
      ST_FIX:  state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (kill) state_n = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag_b  <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (!kill) begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            op_q   <= op;
            sign_a <= rs1_neg;
            sign_b <= rs2_neg;
            mag_b  <= rs2_mag;
            acc    <= {{XLEN{1'b0}}, rs1_mag};
            cnt    <= '0;
            if (div_zero || div_ovf) result <= special_res;
          end
        end
        ST_CALC: begin
          acc <= is_div(op_q) ? div_next : mul_next;
          cnt <= cnt + CW'(1);
        end
        ST_FIX:  result <= fix_res;
        default: ;
      endcase
    end
  end

  assign busy  = (state == ST_CALC) || (state == ST_FIX);
  assign ready = (state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit_ctrl.sv
// ============================================================================
// tb_muldiv_unit_ctrl : directed + randomized checks against an arithmetic
//                       reference model of the RV32M M-extension ops
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit_ctrl;

  localparam int XLEN     = 32;
  localparam int NORM_LAT = XLEN + 2;

  logic            clk = 1'b0;
  logic            rst, start, kill;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            busy, ready;
  logic [XLEN-1:0] result;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] last_exp = '0;

  muldiv_unit_ctrl #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .kill     (kill),
    .op       (op),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .busy     (busy),
    .ready    (ready),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ua = longint'({32'd0, a});
    longint      ub = longint'({32'd0, b});
    logic [63:0] p;
    bit          ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = 64'(ua * ub); return p[31:0];  end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return a;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'd0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
    return o[2] && ((b == 0) ||
           ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs1_data = a; rs2_data = b;
  endtask

  // Start is already driven; the next posedge ends cycle 0.
  task automatic wait_done(input string tag, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input bit hold);
    logic [31:0] exp = ref_result(o, a, b);
    bit          spc = is_special(o, a, b);
    int          lat = 0;
    int          busy_cycles = 0;
    @(posedge clk);
    for (int n = 1; n <= NORM_LAT + 10 && lat == 0; n++) begin
      @(negedge clk);
      if (n == 1 && !hold) begin
        start = 1'b0; op = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
      end
      if (busy)  busy_cycles++;
      if (ready) lat = n;
    end
    check_eq({tag, " latency"}, lat, spc ? 1 : NORM_LAT);
    check_eq({tag, " busy"}, busy_cycles, spc ? 0 : NORM_LAT - 1);
    check_eq({tag, " result"}, result, exp);
    last_exp = exp;
  endtask

  logic [2:0]  d_op [14] = '{3'd1, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5,
                             3'd7, 3'd5, 3'd6, 3'd4, 3'd6, 3'd0, 3'd7};
  logic [31:0] d_a  [14] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                             32'h80000000, 32'h80000000, 32'h12345678, 32'd9};
  logic [31:0] d_b  [14] = '{32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'h9ABCDEF0, 32'd0};

  initial begin
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; rs1_data = '0; rs2_data = '0;
    repeat (3) @(negedge clk);
    check_eq("reset busy", 32'(busy), 0);
    check_eq("reset ready", 32'(ready), 0);
    check_eq("reset result", result, 0);
    rst = 1'b0;

    // MUL with start held high through DONE: no re-issue until IDLE
    issue(3'd0, 32'd7, 32'hFFFFFFFD);
    wait_done("mul hold", 3'd0, 32'd7, 32'hFFFFFFFD, 1'b1);
    @(negedge clk);
    check_eq("hold idle busy", 32'(busy), 0);
    check_eq("hold ready pulse", 32'(ready), 0);
    @(negedge clk);
    check_eq("hold reaccept busy", 32'(busy), 1);
    start = 1'b0;
    begin
      int seen = 0;
      for (int n = 0; n < NORM_LAT + 10 && seen == 0; n++) begin
        @(negedge clk);
        if (ready) seen = 1;
      end
      check_eq("hold reissue done", seen, 1);
      check_eq("hold reissue result", result, 32'hFFFFFFEB);
    end

    for (int i = 0; i < 14; i++) begin
      issue(d_op[i], d_a[i], d_b[i]);
      wait_done($sformatf("dir%0d op%0d", i, d_op[i]), d_op[i], d_a[i], d_b[i], 1'b0);
    end

    // kill in cycle 10 of a divide, new start in cycle 11
    issue(3'd4, 32'd1000, 32'd3);
    @(posedge clk);
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check_eq("kill busy", 32'(busy), 0);
    check_eq("kill result held", result, last_exp);
    start = 1'b1; op = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7;
    wait_done("after kill", 3'd5, 32'd100, 32'd7, 1'b0);

    // start and kill together in IDLE
    @(negedge clk);
    start = 1'b1; kill = 1'b1; op = 3'd4; rs1_data = 32'd50; rs2_data = 32'd0;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check_eq("start+kill busy", 32'(busy), 0);
    check_eq("start+kill ready", 32'(ready), 0);
    check_eq("start+kill result", result, last_exp);

    // reset mid-CALC
    issue(3'd3, 32'hDEADBEEF, 32'h12345678);
    @(posedge clk);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst busy", 32'(busy), 0);
    check_eq("rst result", result, 0);
    begin
      int rdy = 0;
      for (int n = 0; n < NORM_LAT + 5; n++) begin
        @(negedge clk);
        if (ready) rdy++;
      end
      check_eq("rst no ready", rdy, 0);
    end
    last_exp = '0;

    // randomized back-to-back with special-case bias
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  ro = 3'($urandom_range(0, 7));
      logic [31:0] ra = $urandom;
      logic [31:0] rb = $urandom;
      int          sel = int'($urandom_range(0, 9));
      if (sel == 0) rb = 32'd0;
      if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      if (sel == 2) begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
      if (sel == 3) rb = -32'($urandom_range(1, 20));
      issue(ro, ra, rb);
      wait_done($sformatf("rnd%0d op%0d", i, ro), ro, ra, rb, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
